bm_core_multiout: RTL and testbench

- Parametrised successor of the single-output BondMachine processor.
- Executes instructions fetched from an external combinational ROM.
- Has 2^REG_AW general registers and N_OUT output channels, each with a valid/received handshake.
- Adds DEC and JZ opcodes and per-channel output back-pressure. Instantiated inside an a<N> wrapper next to its ROM.

---
 rtl/bm_core_multiout.sv | 134 +++++++++++++
 tb/tb_bm_core_multiout.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bm_core_multiout.sv
// bm_core_multiout: BondMachine-style processor core with 2^REG_AW registers
// and N_OUT output channels, each with a valid/received handshake.
// Instructions come from an external combinational ROM addressed by rom_bus.
// Optional build macro BM_CORE_STALL_ON_BUSY_EN: when defined, R2O to a busy
// channel stalls until the channel frees; when undefined, R2O overwrites the
// busy channel and execution continues (legacy behaviour).
module bm_core_multiout #(
    parameter int unsigned DW     = 8,
    parameter int unsigned REG_AW = 1,
    parameter int unsigned N_OUT  = 2,
    parameter int unsigned OUT_AW = 1,
    parameter int unsigned PC_W   = 3
) (
    input  logic                      clock_signal,
    input  logic                      reset_signal,
    output logic [PC_W-1:0]           rom_bus,
    input  logic [3+REG_AW+DW-1:0]    rom_value,
    output logic [N_OUT*DW-1:0]       o,
    output logic [N_OUT-1:0]          o_valid,
    input  logic [N_OUT-1:0]          o_received
);

    localparam int unsigned IW   = 3 + REG_AW + DW;
    localparam int unsigned NREG = 2 ** REG_AW;

    typedef enum logic [2:0] {
        OP_CLR  = 3'b000,
        OP_CPY  = 3'b001,
        OP_INC  = 3'b010,
        OP_J    = 3'b011,
        OP_R2O  = 3'b100,
        OP_RSET = 3'b101,
        OP_DEC  = 3'b110,
        OP_JZ   = 3'b111
    } op_e;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   reg_q [NREG];
    logic [DW-1:0]   reg_d [NREG];
    logic [DW-1:0]   out_q [N_OUT];
    logic [DW-1:0]   out_d [N_OUT];
    logic [N_OUT-1:0] valid_q, valid_d;

    op_e               op_c;
    logic [REG_AW-1:0] rd_c;
    logic [DW-1:0]     imm_c;
    logic [REG_AW-1:0] rs_c;
    logic [OUT_AW-1:0] oi_c;
    logic [PC_W-1:0]   tgt_c;
    logic [PC_W-1:0]   pc_inc_c;
    logic [N_OUT-1:0]  busy_c;

    // Instruction field decode
    always_comb begin
        op_c     = op_e'(rom_value[IW-1 -: 3]);
        rd_c     = rom_value[IW-4 -: REG_AW];
        imm_c    = rom_value[DW-1:0];
        rs_c     = imm_c[DW-1 -: REG_AW];
        oi_c     = imm_c[DW-1 -: OUT_AW];
        tgt_c    = imm_c[PC_W-1:0];
        pc_inc_c = pc_q + PC_W'(1);
        busy_c   = valid_q & ~o_received;
    end

    // Next-state: execute the current instruction and track channel handshakes
    always_comb begin
        pc_d    = pc_inc_c;
        reg_d   = reg_q;
        out_d   = out_q;
        valid_d = valid_q & ~o_received;

        case (op_c)
            OP_CLR:  reg_d[rd_c] = '0;
            OP_CPY:  reg_d[rd_c] = reg_q[rs_c];
            OP_INC:  reg_d[rd_c] = reg_q[rd_c] + DW'(1);
            OP_J:    pc_d        = tgt_c;
            OP_R2O: begin
                // Indices beyond N_OUT match no channel and just advance pc
                for (int k = 0; k < N_OUT; k++) begin
                    if (oi_c == OUT_AW'(k)) begin
`ifdef BM_CORE_STALL_ON_BUSY_EN
                        if (busy_c[k]) begin
                            pc_d = pc_q;
                        end else begin
                            out_d[k]   = reg_q[rd_c];
                            valid_d[k] = 1'b1;
                        end
`else
                        out_d[k]   = reg_q[rd_c];
                        valid_d[k] = 1'b1;
`endif
                    end
                end
            end
            OP_RSET: reg_d[rd_c] = imm_c;
            OP_DEC:  reg_d[rd_c] = reg_q[rd_c] - DW'(1);
            OP_JZ: begin
                if (reg_q[rd_c] == '0) begin
                    pc_d = tgt_c;
                end
            end
            default: pc_d = pc_inc_c;
        endcase
    end

    // State registers with asynchronous reset
    always_ff @(posedge clock_signal or posedge reset_signal) begin
        if (reset_signal) begin
            pc_q    <= '0;
            valid_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                reg_q[i] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                out_q[k] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            valid_q <= valid_d;
            reg_q   <= reg_d;
            out_q   <= out_d;
        end
    end

    // Drive ports straight from the registers
    always_comb begin
        rom_bus = pc_q;
        o_valid = valid_q;
        for (int k = 0; k < N_OUT; k++) begin
            o[k*DW +: DW] = out_q[k];
        end
    end

endmodule

// File: tb/tb_bm_core_multiout.sv
// Directed bench for bm_core_multiout: reset, handshake, counting loop,
// wrap-around, busy channel (either build of BM_CORE_STALL_ON_BUSY_EN) and
// out-of-range output index on a second instance with OUT_AW=2.
module tb_bm_core_multiout;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rom_bus;
    logic [11:0] rom_value;
    logic [15:0] o;
    logic [1:0]  o_valid;
    logic [1:0]  o_received;
    logic [11:0] rom [8];

    logic        rst2;
    logic [2:0]  rom_bus2;
    logic [11:0] rom_value2;
    logic [15:0] o2;
    logic [1:0]  o_valid2;
    logic [1:0]  o_received2;
    logic [11:0] rom2 [8];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign rom_value  = rom[rom_bus];
    assign rom_value2 = rom2[rom_bus2];

    bm_core_multiout dut (
        .clock_signal (clk),
        .reset_signal (rst),
        .rom_bus      (rom_bus),
        .rom_value    (rom_value),
        .o            (o),
        .o_valid      (o_valid),
        .o_received   (o_received)
    );

    bm_core_multiout #(.OUT_AW(2)) dut_oor (
        .clock_signal (clk),
        .reset_signal (rst2),
        .rom_bus      (rom_bus2),
        .rom_value    (rom_value2),
        .o            (o2),
        .o_valid      (o_valid2),
        .o_received   (o_received2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [11:0] w0, input logic [11:0] w1,
                        input logic [11:0] w2, input logic [11:0] w3,
                        input logic [11:0] w4, input logic [11:0] w5,
                        input logic [11:0] w6, input logic [11:0] w7);
        rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
        rom[4] = w4; rom[5] = w5; rom[6] = w6; rom[7] = w7;
    endtask

    task automatic chk_pc(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_v(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_o(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    initial begin
        rst         = 1'b1;
        rst2        = 1'b1;
        o_received  = 2'b00;
        o_received2 = 2'b00;
        // RSET r0,0x5A / R2O r0,o0 / J 2
        load(12'hA5A, 12'h800, 12'h602, 12'h602, 12'h602, 12'h602, 12'h602, 12'h602);
        // RSET r0,0x33 / R2O r0,oi3 / R2O r0,oi1 / J 3
        rom2[0] = 12'hA33; rom2[1] = 12'h8C0; rom2[2] = 12'h840; rom2[3] = 12'h603;
        rom2[4] = 12'h603; rom2[5] = 12'h603; rom2[6] = 12'h603; rom2[7] = 12'h603;

        #12;
        chk_pc("rst_pc", rom_bus, 3'd0);
        chk_o ("rst_o", o, 16'h0000);
        chk_v ("rst_valid", o_valid, 2'b00);

        rst = 1'b0;
        tick();
        chk_pc("a_pc1", rom_bus, 3'd1);
        chk_v ("a_valid_e1", o_valid, 2'b00);
        tick();
        chk_o ("a_o_5a", o, 16'h005A);
        chk_v ("a_valid_e2", o_valid, 2'b01);
        chk_pc("a_pc2", rom_bus, 3'd2);

        o_received = 2'b01;
        tick();
        chk_v ("hs_clear", o_valid, 2'b00);
        chk_o ("hs_hold", o, 16'h005A);
        o_received = 2'b00;
        tick();
        chk_v ("hs_idle", o_valid, 2'b00);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk_pc("async_pc", rom_bus, 3'd0);
        chk_o ("async_o", o, 16'h0000);
        chk_v ("async_valid", o_valid, 2'b00);

        // RSET r1,3 / DEC r1 / JZ r1,4 / J 1 / R2O r1,o1 / J 5
        load(12'hB03, 12'hD00, 12'hF04, 12'h601, 12'h980, 12'h605, 12'h605, 12'h605);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk_pc("cnt_pc3", rom_bus, 3'd3);
        tick();
        chk_pc("cnt_jback", rom_bus, 3'd1);
        repeat (5) tick();
        chk_pc("cnt_jz_taken", rom_bus, 3'd4);
        chk_v ("cnt_valid_e9", o_valid, 2'b00);
        tick();
        chk_v ("cnt_valid_e10", o_valid, 2'b10);
        chk_o ("cnt_o", o, 16'h0000);
        chk_pc("cnt_pc5", rom_bus, 3'd5);

        rst = 1'b1;
        #1;
        chk_v ("rst2_valid", o_valid, 2'b00);
        // CLR r0 / DEC r0 / R2O r0,o0 / J 7 / ... / INC r0 at 7
        load(12'h000, 12'hC00, 12'h800, 12'h607, 12'h000, 12'h000, 12'h000, 12'h400);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk_o ("wrap_dec", o, 16'h00FF);
        chk_v ("wrap_valid", o_valid, 2'b01);
        tick();
        chk_pc("wrap_pc7", rom_bus, 3'd7);
        tick();
        chk_pc("wrap_pc0", rom_bus, 3'd0);

        rst = 1'b1;
        #1;
        // RSET r0,11 / RSET r1,22 / R2O r0,o0 / R2O r1,o0 / CPY r0,r1 / INC r0 / R2O r0,o1 / R2O r0,o0
        load(12'hA11, 12'hB22, 12'h800, 12'h900, 12'h280, 12'h400, 12'h880, 12'h800);
        #2;
        rst = 1'b0;
        repeat (3) tick();
        chk_o ("busy_first", o, 16'h0011);
        chk_v ("busy_first_v", o_valid, 2'b01);
        chk_pc("busy_pc3", rom_bus, 3'd3);
        tick();
`ifdef BM_CORE_STALL_ON_BUSY_EN
        chk_pc("stall_pc", rom_bus, 3'd3);
        chk_o ("stall_o", o, 16'h0011);
        chk_v ("stall_v", o_valid, 2'b01);
        tick();
        chk_pc("stall_pc_again", rom_bus, 3'd3);
        o_received = 2'b01;
        tick();
        chk_o ("stall_release_o", o, 16'h0022);
        chk_v ("stall_release_v", o_valid, 2'b01);
        chk_pc("stall_release_pc", rom_bus, 3'd4);
        o_received = 2'b00;
`else
        chk_o ("overwrite_o", o, 16'h0022);
        chk_v ("overwrite_v", o_valid, 2'b01);
        chk_pc("overwrite_pc", rom_bus, 3'd4);
`endif
        repeat (3) tick();
        chk_o ("cpy_inc_o1", o, 16'h2322);
        chk_v ("cpy_inc_v", o_valid, 2'b11);
        chk_pc("busy_pc7", rom_bus, 3'd7);
        o_received = 2'b01;
        tick();
        chk_o ("simul_o", o, 16'h2323);
        chk_v ("simul_v", o_valid, 2'b11);
        chk_pc("simul_pc_wrap", rom_bus, 3'd0);
        o_received = 2'b00;
        tick();
        chk_v ("hold_v", o_valid, 2'b11);

        #2;
        rst = 1'b1;
        #1;
        chk_o ("async2_o", o, 16'h0000);
        chk_v ("async2_v", o_valid, 2'b00);
        chk_pc("async2_pc", rom_bus, 3'd0);

        // Out-of-range index on the OUT_AW=2 instance
        rst2 = 1'b0;
        tick();
        chk_pc("oor_pc1", rom_bus2, 3'd1);
        tick();
        chk_v ("oor_noop_v", o_valid2, 2'b00);
        chk_o ("oor_noop_o", o2, 16'h0000);
        chk_pc("oor_pc2", rom_bus2, 3'd2);
        tick();
        chk_v ("oor_inrange_v", o_valid2, 2'b10);
        chk_o ("oor_inrange_o", o2, 16'h3300);
        chk_pc("oor_pc3", rom_bus2, 3'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
